// File: rtl/key_conditioner.sv
// key_conditioner
//
// Conditions the four raw push-buttons for the Tetris game controller. Each key
// goes through a two-flop synchroniser and a debouncer. The block then emits a
// registered single-cycle pulse on every accepted press. Held keys can
// optionally auto-repeat.
//
// Optional feature:
//   Define KEY_AUTOREPEAT_EN to build the per-key repeat FSMs. These use
//   REPEAT_DELAY, REPEAT_PERIOD and REPEAT_MASK.
//   When the macro is undefined, those parameters are accepted but ignored,
//   and only press pulses are produced.
//
// Parameters:
//   DEBOUNCE_CYCLES - cycles a synchronised level must persist before acceptance (>=2)
//   REPEAT_DELAY    - cycles from the press pulse to the first repeat pulse (>=2)
//   REPEAT_PERIOD   - cycles between later repeat pulses (>=2)
//   REPEAT_MASK     - per-key auto-repeat enable, bit order as op_keys
//
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   keys_raw  - asynchronous button levels, 1 = pressed; [0] up, [1] down, [2] left, [3] right
//   op_keys   - registered one-cycle pulse per accepted press or repeat
//   keys_held - registered debounced level per key

module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 15000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter logic [3:0]  REPEAT_MASK     = 4'b1110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keys_raw,
  output logic [3:0] op_keys,
  output logic [3:0] keys_held
);

  localparam logic [23:0] DebTerm = 24'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [23:0] DelayTerm  = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] PeriodTerm = 24'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } rep_state_e;
`else
  // Repeat configuration is accepted but has no effect in this build.
  logic [23:0] unused_cfg;
  assign unused_cfg = 24'(REPEAT_DELAY) ^ 24'(REPEAT_PERIOD) ^ {20'd0, REPEAT_MASK};
`endif

  for (genvar i = 0; i < 4; i++) begin : g_key
    logic        sync1;
    logic        s;
    logic        stable;
    logic [23:0] dcnt;
    logic        accept;
    logic        press_ev;
    logic        rel_ev;
    logic        pulse;

    // Accept the new level when the mismatch has persisted for DEBOUNCE_CYCLES cycles.
    assign accept   = (s != stable) && (dcnt == DebTerm);
    assign press_ev = accept && s;
    assign rel_ev   = accept && !s;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1  <= 1'b0;
        s      <= 1'b0;
        stable <= 1'b0;
        dcnt   <= '0;
      end else begin
        sync1 <= keys_raw[i];
        s     <= sync1;
        if (s == stable) begin
          dcnt <= '0;
        end else if (dcnt == DebTerm) begin
          stable <= s;
          dcnt   <= '0;
        end else begin
          dcnt <= dcnt + 24'd1;
        end
      end
    end

    assign keys_held[i] = stable;

`ifdef KEY_AUTOREPEAT_EN
    rep_state_e  state;
    logic [23:0] rcnt;

    // The press pulse is issued from IDLE. A key whose mask bit is clear stays in IDLE.
    // A release always wins over a coinciding terminal count, so no pulse is issued then.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= StIdle;
        rcnt  <= '0;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (rel_ev) begin
          state <= StIdle;
          rcnt  <= '0;
        end else begin
          unique case (state)
            StIdle: begin
              rcnt <= '0;
              if (press_ev) begin
                pulse <= 1'b1;
                if (REPEAT_MASK[i]) begin
                  state <= StDelay;
                end
              end
            end
            StDelay: begin
              if (rcnt == DelayTerm) begin
                pulse <= 1'b1;
                state <= StRepeat;
                rcnt  <= '0;
              end else begin
                rcnt <= rcnt + 24'd1;
              end
            end
            StRepeat: begin
              if (rcnt == PeriodTerm) begin
                pulse <= 1'b1;
                rcnt  <= '0;
              end else begin
                rcnt <= rcnt + 24'd1;
              end
            end
            default: begin
              state <= StIdle;
              rcnt  <= '0;
            end
          endcase
        end
      end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pulse <= 1'b0;
      end else begin
        pulse <= press_ev;
      end
    end
`endif

    assign op_keys[i] = pulse;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed testbench for key_conditioner.
// It uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10 and REPEAT_PERIOD=5.
// Expected repeat pulses depend on whether KEY_AUTOREPEAT_EN is defined.
// Each stimulus profile is a bit vector indexed by clock edge number k, counted from
// the start of the sequence:
//   raw   - the level sampled at edge k
//   held  - the expected keys_held level just after edge k
//   pulse - the expected op_keys level just after edge k

module tb_key_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] keys_raw;
  logic [3:0] op_keys;
  logic [3:0] keys_held;

  int n_checks = 0;
  int n_errors = 0;

  key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5),
    .REPEAT_MASK    (4'b1110)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .keys_raw (keys_raw),
    .op_keys  (op_keys),
    .keys_held(keys_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rng(int lo, int hi);
    logic [63:0] m;
    m = '0;
    for (int b = lo; b <= hi; b++) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bitk(int k);
    logic [63:0] m;
    m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic run_seq(string tag, logic [3:0] kmask, int n, logic [63:0] raw_p,
                         logic [63:0] held_p, logic [63:0] pulse_p);
    for (int k = 1; k <= n; k++) begin
      keys_raw = raw_p[k] ? kmask : 4'b0000;
      @(posedge clk);
      #1;
      check($sformatf("%s op_keys@%0d", tag, k), op_keys, pulse_p[k] ? kmask : 4'b0000);
      check($sformatf("%s keys_held@%0d", tag, k), keys_held, held_p[k] ? kmask : 4'b0000);
    end
  endtask

  logic [63:0] p_bounce;
  logic [63:0] p_hold;
  logic [63:0] p_rst;

  initial begin
`ifdef KEY_AUTOREPEAT_EN
    // Press at 6, first repeat at 16, then 21. The terminal count at 26 meets the release.
    p_bounce = bitk(6) | bitk(16) | bitk(21);
    p_hold   = bitk(6) | bitk(16) | bitk(21) | bitk(26) | bitk(31) | bitk(36) | bitk(41);
    p_rst    = bitk(6) | bitk(16) | bitk(21);
`else
    p_bounce = bitk(6);
    p_hold   = bitk(6);
    p_rst    = bitk(6);
`endif

    rst      = 1'b0;
    keys_raw = 4'b0000;
    #1 rst = 1'b1;
    #1;
    check("reset op_keys", op_keys, 4'b0000);
    check("reset keys_held", keys_held, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    check("reset op_keys clocked", op_keys, 4'b0000);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Clean press on left.
    run_seq("left_press", 4'b0100, 18, rng(1, 8), rng(6, 13), bitk(6));

    // Short glitch on right: no acceptance.
    run_seq("right_glitch", 4'b1000, 10, rng(1, 3), '0, '0);

    // 20-cycle press with a 2-cycle bounce low inside.
    run_seq("right_bounce", 4'b1000, 32, rng(1, 7) | rng(10, 20), rng(6, 25), p_bounce);

    // Down held 40 cycles after acceptance. The repeat due at 46 meets the release.
    run_seq("down_hold", 4'b0010, 55, rng(1, 40), rng(6, 45), p_hold);
    // The FSM is back in IDLE, so a short press gives one press pulse only.
    run_seq("down_again", 4'b0010, 18, rng(1, 8), rng(6, 13), bitk(6));

    // Rotate is masked from repeating.
    run_seq("up_hold", 4'b0001, 55, rng(1, 40), rng(6, 45), bitk(6));

    // Left and right pressed together.
    run_seq("left_right", 4'b1100, 16, rng(1, 7), rng(6, 12), bitk(6));

    // Reset during the repeat phase with down still held.
    run_seq("down_pre_rst", 4'b0010, 21, rng(1, 21), rng(6, 21), p_rst);
    #2 rst = 1'b1;
    #1;
    check("mid_rst op_keys", op_keys, 4'b0000);
    check("mid_rst keys_held", keys_held, 4'b0000);
    @(posedge clk);
    #1;
    check("mid_rst op_keys clocked", op_keys, 4'b0000);
    rst = 1'b0;
    run_seq("down_post_rst", 4'b0010, 8, rng(1, 8), rng(6, 8), bitk(6));
    run_seq("down_release", 4'b0010, 10, '0, rng(1, 5), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input conditioning stage directly upstream of the Tetris game controller. Takes the four raw push-button levels (up/rotate, down, left, right), synchronises and debounces them, and emits one-clock `op_keys` pulses, with optional auto-repeat for held keys. The controller latches these pulses between `draw_finish` frames, so every press or repeat must appear as exactly one clean single-cycle pulse.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a synchronised level must persist before it is accepted (≥2).
- `REPEAT_DELAY`, 15000000: cycles from the press pulse to the first repeat pulse (≥2).
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat pulses (≥2).
- `REPEAT_MASK`, 4'b1110: per-key auto-repeat enable. Bit order matches `op_keys`. Rotate does not repeat by default.
- All three counts must fit in 24 bits.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset; asynchronous, active-high.
- `keys_raw` input 4: asynchronous button levels, 1 = pressed; [0] up, [1] down, [2] left, [3] right.
- `op_keys` output 4: registered one-cycle pulse per accepted press or repeat.
- `keys_held` output 4: registered debounced level per key.

## Operation
- Per key, independent and identical:
  - two-flop synchroniser → `s`
  - debounce counter `dcnt` (24 bit)
  - accepted level `stable` (drives `keys_held`)
  - repeat FSM with counter `rcnt` (24 bit)
- Debounce:
  - If `s == stable`, `dcnt` ← 0.
  - Otherwise, `dcnt` increments.
  - When `s != stable` and `dcnt == DEBOUNCE_CYCLES-1`, `stable` ← `s` and `dcnt` ← 0.
  - A mismatch shorter than `DEBOUNCE_CYCLES` cycles changes nothing.
- Press event: `stable` 0→1. `op_keys[i]` is 1 for exactly the cycle following that edge.
- Release event: `stable` 1→0. Never pulses.
- Repeat FSM states IDLE, DELAY, REPEAT:
  - IDLE → DELAY on press event; `rcnt` ← 0.
  - In DELAY, `rcnt` increments each cycle. At `rcnt == REPEAT_DELAY-1`: pulse, → REPEAT, `rcnt` ← 0.
  - In REPEAT, `rcnt` increments each cycle. At `rcnt == REPEAT_PERIOD-1`: pulse, `rcnt` ← 0.
  - Release event from any state → IDLE, `rcnt` ← 0. No pulse is emitted in the release cycle, even if a terminal count coincides with it.
  - Keys with `REPEAT_MASK[i]` = 0 stay in IDLE and never enter DELAY.
- Keys do not interact:
  - Simultaneous presses pulse in the same cycle.
  - No priority and no mutual exclusion; the controller resolves conflicting keys.
- Counters never wrap. Each one is cleared at its terminal count or on a state change.

## Timing
- Reset (asynchronous assert; deassert is synchronous to `clk` and is handled by the top level). The following are 0 and all FSMs are in IDLE:
  - `op_keys`, `keys_held`
  - synchroniser flops, `stable`, `dcnt`, `rcnt`
- Press latency:
  - Raw high first sampled at edge 1 → `s` high after edge 2.
  - `stable` and `keys_held` go high after edge `DEBOUNCE_CYCLES+2`.
  - `op_keys` goes high after the same edge and is low again after the next edge.
- Release latency: `keys_held` falls after edge `DEBOUNCE_CYCLES+2` relative to the raw falling sample.
- Repeat spacing:
  - First repeat pulse is `REPEAT_DELAY` cycles after the press pulse.
  - Following repeat pulses are exactly `REPEAT_PERIOD` cycles apart.
- `op_keys` is never high for two consecutive cycles on the same bit.
- Reset asserted mid-press or mid-repeat: outputs clear immediately. A key still held after release of reset is debounced afresh and produces a new press pulse.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: repeat FSMs, `rcnt`, `REPEAT_DELAY`/`REPEAT_PERIOD`/`REPEAT_MASK` behaviour as above.
- Undefined: repeat logic is not compiled in. Parameters remain declared but are ignored. Only press pulses are emitted, one per debounced press regardless of hold time.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5, macro defined unless stated.
- Reset then clean press on `keys_raw[2]`, held 8 cycles: `keys_held[2]` and `op_keys[2]` rise after edge 6; `op_keys[2]` is exactly 1 cycle wide; no further pulses.
- Glitch `keys_raw[3]` high for 3 cycles, then 2-cycle bounce low inside a 20-cycle press: no pulse from the glitch; exactly one press pulse for the press.
- Hold `keys_raw[1]` 40 cycles after acceptance: pulses at acceptance +0, +10, +15, +20, +25, +30, +35; release produces no pulse and returns the FSM to IDLE.
- Hold `keys_raw[0]` 40 cycles with default mask: exactly one pulse on `op_keys[0]`.
- Press left and right on the same cycle: `op_keys` = 4'b1100 for one cycle.
- Assert `rst` during the repeat phase with key still held, release `rst`: outputs 0 immediately; a new press pulse occurs 6 edges after reset release. With the macro undefined, a 40-cycle hold yields exactly one pulse.
